mmio_io_bank: RTL and testbench

//  Parametrised memory-mapped I/O peripheral for the single-cycle RV32 core; generalises the LED-only IO driver.

---
 rtl/mmio_io_bank.sv | 176 +++++++++++++++++
 tb/tb_mmio_io_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_bank
// Description : Memory-mapped I/O bank for the single-cycle RV32 core. It has
//               NUM_OUT writable output channels and one two-flop-synchronised
//               input port with rising-edge capture and a level interrupt.
//               Reads are combinational, so a load completes in the same cycle.
//               Optional feature macro: MMIO_EDGE_IRQ_EN builds the EDGE /
//               IRQ_EN registers and the arm counter; without it those read 0
//               and irq is tied low.
// Ports       : clk      - rising-edge clock
//               reset    - asynchronous, active-low reset
//               we       - store strobe; effective only when addr[SEL_BIT]=1
//               addr     - byte address, register index = addr[5:2]
//               wmask    - byte enables for writes
//               wdata    - write data
//               rdata    - combinational read data
//               is_io    - addr[SEL_BIT], used to gate the data memory
//               gpio_out - channel i on bits [i*OUT_W +: OUT_W]
//               gpio_in  - asynchronous external inputs
//               irq      - |(EDGE & IRQ_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_bank #(
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = 5,
    parameter int IN_W    = 8,
    parameter int SEL_BIT = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [3:0]               wmask,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     is_io,
    output logic [NUM_OUT*OUT_W-1:0] gpio_out,
    input  logic [IN_W-1:0]          gpio_in,
    output logic                     irq
);

    localparam logic [3:0]  c_IDX_IN     = 4'd8;
    localparam logic [3:0]  c_IDX_EDGE   = 4'd9;
    localparam logic [3:0]  c_IDX_IRQ_EN = 4'd10;
    localparam logic [3:0]  c_IDX_ID     = 4'd11;
    localparam logic [31:0] c_ID         = {8'd0, 8'(NUM_OUT), 8'(OUT_W), 8'(IN_W)};

    logic [3:0]               w_idx;
    logic                     w_wr;
    logic [31:0]              w_bmask;
    logic [31:0]              w_merged;
    logic [NUM_OUT*OUT_W-1:0] r_out;
    logic [IN_W-1:0]          r_s1;
    logic [IN_W-1:0]          r_s2;
    logic [IN_W-1:0]          w_edge_rd;
    logic [IN_W-1:0]          w_irq_en_rd;

    assign w_idx   = addr[5:2];
    assign is_io   = addr[SEL_BIT];
    assign w_wr    = we & addr[SEL_BIT];
    assign w_bmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

    // rdata already holds the zero-extended current value of the addressed
    // register, so the byte-masked merge for any R/W register starts from it.
    assign w_merged = (rdata & ~w_bmask) | (wdata & w_bmask);

    // Address bits outside [5:2] and merge bits above a register's width are
    // intentionally dropped.
    logic w_unused_bits;
    assign w_unused_bits = ^{addr[31:6], addr[1:0], w_merged};

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_idx == 4'(i)) begin
                    r_out[i*OUT_W +: OUT_W] <= w_merged[OUT_W-1:0];
                end
            end
        end
    end

    assign gpio_out = r_out;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= gpio_in;
            r_s2 <= r_s1;
        end
    end

`ifdef MMIO_EDGE_IRQ_EN
    // ------------------------------------------------------------------
    // Edge capture, interrupt enable and arm counter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ARM_WAIT0 = 2'd0,
        ARM_WAIT1 = 2'd1,
        ARM_ON    = 2'd2
    } arm_state_t;

    arm_state_t      r_arm;
    logic [IN_W-1:0] r_edge;
    logic [IN_W-1:0] r_irq_en;
    logic [IN_W-1:0] w_rise;
    logic [IN_W-1:0] w_clr;
    logic            w_armed;

    assign w_rise  = r_s1 & ~r_s2;
    assign w_armed = (r_arm == ARM_ON);
    assign w_clr   = (w_wr && (w_idx == c_IDX_EDGE)) ? w_merged[IN_W-1:0] & w_bmask[IN_W-1:0]
                                                      : '0;

    // The arm counter masks the two cycles in which the synchroniser fills
    // from reset, so inputs already high at release do not look like rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm    <= ARM_WAIT0;
            r_edge   <= '0;
            r_irq_en <= '0;
        end else begin
            case (r_arm)
                ARM_WAIT0: r_arm <= ARM_WAIT1;
                ARM_WAIT1: r_arm <= ARM_ON;
                ARM_ON:    r_arm <= ARM_ON;
                default:   r_arm <= ARM_WAIT0;
            endcase
            // Set is OR-ed after the clear so a same-cycle rise wins.
            r_edge <= (r_edge & ~w_clr) | (w_rise & {IN_W{w_armed}});
            if (w_wr && (w_idx == c_IDX_IRQ_EN)) begin
                r_irq_en <= w_merged[IN_W-1:0];
            end
        end
    end

    assign w_edge_rd   = r_edge;
    assign w_irq_en_rd = r_irq_en;
    assign irq         = |(r_edge & r_irq_en);
`else
    assign w_edge_rd   = '0;
    assign w_irq_en_rd = '0;
    assign irq         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_idx == 4'(i)) begin
                rdata[OUT_W-1:0] = r_out[i*OUT_W +: OUT_W];
            end
        end
        case (w_idx)
            c_IDX_IN:     rdata[IN_W-1:0] = r_s2;
            c_IDX_EDGE:   rdata[IN_W-1:0] = w_edge_rd;
            c_IDX_IRQ_EN: rdata[IN_W-1:0] = w_irq_en_rd;
            c_IDX_ID:     rdata           = c_ID;
            default:      ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_io_bank
// Description : Directed, self-checking bench for mmio_io_bank at default
//               parameters. Stimulus pushes expected values into a queue; a
//               monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_bank;

`ifdef MMIO_EDGE_IRQ_EN
    localparam bit c_EI = 1'b1;
`else
    localparam bit c_EI = 1'b0;
`endif

    localparam logic [31:0] c_B      = 32'h0040_0000;
    localparam logic [31:0] c_OUT0   = c_B + 32'h00;
    localparam logic [31:0] c_OUT1   = c_B + 32'h04;
    localparam logic [31:0] c_IN     = c_B + 32'h20;
    localparam logic [31:0] c_EDGE   = c_B + 32'h24;
    localparam logic [31:0] c_IRQEN  = c_B + 32'h28;
    localparam logic [31:0] c_ID     = c_B + 32'h2C;
    localparam logic [31:0] c_IDX13  = c_B + 32'h34;

    localparam int K_RD   = 0;
    localparam int K_GPIO = 1;
    localparam int K_IRQ  = 2;
    localparam int K_IO   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        is_io;
    logic [9:0]  gpio_out;
    logic [7:0]  gpio_in;
    logic        irq;

    int          n_chk = 0;
    int          n_bad = 0;

    int          q_kind[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    mmio_io_bank dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .wmask    (wmask),
        .wdata    (wdata),
        .rdata    (rdata),
        .is_io    (is_io),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Monitor: everything queued during the current cycle is checked here.
    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            int          k;
            logic [31:0] e;
            logic [31:0] a;
            string       nm;
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            case (k)
                K_RD:    a = rdata;
                K_GPIO:  a = 32'(gpio_out);
                K_IRQ:   a = {31'd0, irq};
                default: a = {31'd0, is_io};
            endcase
            n_chk++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: actual=%h expected=%h", nm, a, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wmask = m;
        wdata = d;
        tick();
        we    = 1'b0;
        wmask = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic expect_val(input int k, input logic [31:0] e, input string nm);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        addr = a;
        expect_val(K_RD, e, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        we      = 1'b0;
        addr    = 32'h0;
        wmask   = 4'h0;
        wdata   = 32'h0;
        gpio_in = 8'h00;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // ---- reset mid-run, including during a write ----
        wr(c_OUT0, 4'hF, 32'h1F);
        wr(c_OUT1, 4'hF, 32'h0A);
        expect_val(K_GPIO, 32'h15F, "out_pre_reset");
        tick();
        we    = 1'b1;
        addr  = c_OUT0;
        wmask = 4'hF;
        wdata = 32'h1F;
        #2;
        reset = 1'b0;
        expect_val(K_GPIO, 32'h0, "out_async_reset");
        expect_val(K_IRQ, 32'h0, "irq_async_reset");
        expect_val(K_RD, 32'h0, "rd_async_reset");
        tick();
        we    = 1'b0;
        wmask = 4'h0;
        wdata = 32'h0;
        tick();
        reset = 1'b1;
        rd(c_ID, 32'h0002_0508, "id");
        tick();
        rd(c_OUT1, 32'h0, "out1_after_reset");
        tick();

        // ---- byte-masked output writes ----
        wr(c_OUT0, 4'b0001, 32'hFFFF_FFFF);
        rd(c_OUT0, 32'h1F, "out0_byte0");
        expect_val(K_GPIO, 32'h01F, "gpio_out0");
        tick();
        wr(c_OUT1, 4'b0010, 32'hFFFF_FFFF);
        rd(c_OUT1, 32'h0, "out1_mask_miss");
        tick();
        we    = 1'b1;
        addr  = c_OUT1;
        wmask = 4'b0001;
        wdata = 32'h35;
        expect_val(K_RD, 32'h0, "out1_before_edge");
        tick();
        we    = 1'b0;
        wmask = 4'h0;
        wdata = 32'h0;
        rd(c_OUT1, 32'h15, "out1_trunc");
        expect_val(K_GPIO, 32'h2BF, "gpio_out_both");
        tick();
        wr(c_OUT0, 4'h0, 32'h0);
        rd(c_OUT0, 32'h1F, "out0_mask0");
        tick();

        // ---- region select, aliasing, unmapped and read-only ----
        we    = 1'b1;
        addr  = 32'h0000_0000;
        wmask = 4'hF;
        wdata = 32'h0;
        expect_val(K_IO, 32'h0, "is_io_low");
        tick();
        we    = 1'b0;
        wmask = 4'h0;
        rd(c_OUT0, 32'h1F, "out0_unsel_write");
        expect_val(K_IO, 32'h1, "is_io_high");
        tick();
        rd(c_B | 32'h40, 32'h1F, "out0_alias");
        tick();
        rd(c_IDX13, 32'h0, "idx13");
        tick();
        wr(c_ID, 4'hF, 32'h0);
        wr(c_IN, 4'hF, 32'hFFFF_FFFF);
        rd(c_ID, 32'h0002_0508, "id_ro");
        tick();
        rd(c_IN, 32'h0, "in_ro");
        tick();

        // ---- synchroniser latency and edge capture ----
        wr(c_IRQEN, 4'hF, 32'h01);
        rd(c_IRQEN, c_EI ? 32'h01 : 32'h0, "irq_en_rd");
        expect_val(K_IRQ, 32'h0, "irq_idle");
        tick();
        gpio_in = 8'h81;
        tick();
        rd(c_IN, 32'h0, "in_lat1");
        expect_val(K_IRQ, 32'h0, "irq_pre");
        tick();
        rd(c_IN, 32'h81, "in_lat2");
        expect_val(K_IRQ, c_EI ? 32'h1 : 32'h0, "irq_edge");
        tick();
        rd(c_EDGE, c_EI ? 32'h81 : 32'h0, "edge_set");
        tick();
        wr(32'h0000_0024, 4'hF, 32'hFF);
        rd(c_EDGE, c_EI ? 32'h81 : 32'h0, "edge_unsel_w1c");
        tick();

        // ---- W1C versus same-cycle rise ----
        wr(c_EDGE, 4'hF, 32'h01);
        rd(c_EDGE, c_EI ? 32'h80 : 32'h0, "edge_clr0");
        expect_val(K_IRQ, 32'h0, "irq_clr0");
        tick();
        gpio_in = 8'h80;
        tick();
        tick();
        gpio_in = 8'h81;
        tick();
        wr(c_EDGE, 4'hF, 32'h01);
        rd(c_EDGE, c_EI ? 32'h81 : 32'h0, "edge_set_wins");
        expect_val(K_IRQ, c_EI ? 32'h1 : 32'h0, "irq_set_wins");
        tick();
        wr(c_EDGE, 4'hF, 32'h01);
        rd(c_EDGE, c_EI ? 32'h80 : 32'h0, "edge_clr_later");
        expect_val(K_IRQ, 32'h0, "irq_dropped");
        tick();
        wr(c_IRQEN, 4'hF, 32'h80);
        expect_val(K_IRQ, c_EI ? 32'h1 : 32'h0, "irq_bit7");
        tick();
        wr(c_EDGE, 4'b0010, 32'h80);
        rd(c_EDGE, c_EI ? 32'h80 : 32'h0, "edge_mask_miss");
        tick();
        wr(c_EDGE, 4'b0001, 32'h80);
        rd(c_EDGE, 32'h0, "edge_clr7");
        expect_val(K_IRQ, 32'h0, "irq_clr7");
        tick();

        // ---- inputs high through reset release ----
        gpio_in = 8'hFF;
        reset   = 1'b0;
        expect_val(K_GPIO, 32'h0, "out_reset2");
        tick();
        tick();
        reset = 1'b1;
        rd(c_IN, 32'h0, "in_sync0");
        tick();
        rd(c_IN, 32'h0, "in_sync1");
        tick();
        rd(c_IN, 32'hFF, "in_sync2");
        tick();
        rd(c_EDGE, 32'h0, "edge_disarmed");
        tick();
        wr(c_IRQEN, 4'hF, 32'hFF);
        rd(c_IRQEN, c_EI ? 32'hFF : 32'h0, "irq_en_all");
        expect_val(K_IRQ, 32'h0, "irq_disarmed");
        tick();
        gpio_in = 8'h00;
        tick();
        tick();
        gpio_in = 8'h01;
        tick();
        tick();
        rd(c_EDGE, c_EI ? 32'h01 : 32'h0, "edge_armed");
        expect_val(K_IRQ, c_EI ? 32'h1 : 32'h0, "irq_armed");
        tick();

        tick();
        tick();
        if (q_kind.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: actual=%0d expected=0", q_kind.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
